conv_seq_ctrl: RTL

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl
//   Sequencer for a 3x3x3 convolution datapath. It streams a kernel bank
//   (27 signed bytes) and an 8x8 input tile (64 signed bytes) from a
//   valid/ready byte input into registered buses. It then waits COMPUTE_CYC
//   cycles for the external combinational datapath and captures its 6x6x3
//   result. Finally it drains the 108 result bytes through a valid/ready
//   byte output.
//
//   Parameter
//     COMPUTE_CYC  settle cycles between the last data byte and capture (1..15)
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_data/in_ready   byte input stream (weights, then data)
//     w_reload                force a weight reload on the next frame
//     weight_lin, data_lin    registered kernel bank / input tile to datapath
//     conv_lin                combinational result from datapath
//     out_valid/out_data/out_ready byte output stream (108 result bytes)
//     busy                    low only when idle in LOAD_W with no bytes taken
//     frame_done              one-cycle pulse after the last output transfer
//
//   Build option
//     CONV_SEQ_WKEEP_EN  retain weights across frames; reload only on w_reload
module conv_seq_ctrl #(
    parameter int unsigned COMPUTE_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic         w_reload,
    output logic [215:0] weight_lin,
    output logic [511:0] data_lin,
    input  logic [863:0] conv_lin,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_D,
        COMPUTE,
        CAPTURE,
        DRAIN
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(COMPUTE_CYC - 1);

    state_t            state, state_nxt;
    logic [6:0]        cnt, cnt_nxt;
    logic [3:0]        wcnt, wcnt_nxt;
    logic              frame_done_nxt;
    logic [26:0][7:0]  w_r;
    logic [63:0][7:0]  d_r;
    logic [107:0][7:0] res_r;
    logic              in_xfer;
    logic              out_xfer;
    logic              skip_w;

`ifdef CONV_SEQ_WKEEP_EN
    logic w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid <= 1'b0;
        end else if (state == LOAD_W && in_xfer && cnt == 7'd26) begin
            w_valid <= 1'b1;
        end
    end

    assign skip_w = w_valid && !w_reload;
`else
    logic unused_w_reload;

    assign unused_w_reload = w_reload;
    assign skip_w          = 1'b0;
`endif

    // Gated by rst_n so the port reads not-ready while reset is held, even
    // though the state register already sits at LOAD_W.
    assign in_ready = rst_n && (state == LOAD_W || state == LOAD_D);

    // The frame_done cycle is spent in DRAIN with the output closed; that is
    // the cycle in which w_reload chooses the next frame's entry state.
    assign out_valid  = (state == DRAIN) && !frame_done;
    assign out_data   = out_valid ? res_r[cnt] : '0;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign busy       = !(state == LOAD_W && cnt == '0);
    assign weight_lin = w_r;
    assign data_lin   = d_r;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        wcnt_nxt       = wcnt;
        frame_done_nxt = 1'b0;
        case (state)
            LOAD_W: begin
                if (in_xfer) begin
                    if (cnt == 7'd26) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD_D;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
            LOAD_D: begin
                if (in_xfer) begin
                    if (cnt == 7'd63) begin
                        cnt_nxt   = '0;
                        wcnt_nxt  = WAIT_INIT;
                        state_nxt = COMPUTE;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
            COMPUTE: begin
                if (wcnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            CAPTURE: begin
                cnt_nxt   = '0;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (frame_done) begin
                    state_nxt = skip_w ? LOAD_D : LOAD_W;
                end else if (out_xfer) begin
                    if (cnt == 7'd107) begin
                        cnt_nxt        = '0;
                        frame_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = LOAD_W;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_W;
            cnt        <= '0;
            wcnt       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wcnt       <= wcnt_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r   <= '0;
            d_r   <= '0;
            res_r <= '0;
        end else begin
            if (state == LOAD_W && in_xfer) begin
                w_r[cnt[4:0]] <= in_data;
            end
            if (state == LOAD_D && in_xfer) begin
                d_r[cnt[5:0]] <= in_data;
            end
            if (state == CAPTURE) begin
                res_r <= conv_lin;
            end
        end
    end

endmodule
